// File: rtl/mbox_slave.sv
// Word FIFO mailbox responder on the crossbar req/ack/resp bus, with status and a level interrupt.
// Define MBOX_OVERFLOW_STICKY_EN to add the sticky overflow flag (STATUS[3]) and its IRQ enable (IRQ_EN[1]).
module mbox_slave #(
  parameter int DEPTH         = 8,
  parameter int IRQ_LEVEL_DEF = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [3:0]  bus_be,
  input  logic [31:0] bus_wdata,
  output logic        bus_ack,
  output logic        bus_resp,
  output logic [31:0] bus_rdata,
  output logic        irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef MBOX_OVERFLOW_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_IRQ_EN  = 3'd2;
  localparam logic [2:0] A_IRQ_LVL = 3'd3;

  function automatic logic [7:0] sat_lvl(input logic [7:0] v);
    if (v == 8'd0)
      return 8'd1;
    else if (v > 8'(DEPTH))
      return 8'(DEPTH);
    else
      return v;
  endfunction

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ram_q_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [1:0]    irq_en_reg, irq_en_next;
  logic [7:0]    irq_lvl_reg, irq_lvl_next;
  logic          ovf_reg, ovf_next;
  logic          irq_reg, irq_next;
  logic          resp_reg;
  logic          from_ram_reg;
  logic [31:0]   reg_rdata_reg, reg_rdata_next;
  logic [31:0]   push_data;
  logic [2:0]    sel;
  logic          wr_acc, rd_acc, empty, full, push, pop;
  logic          unused_addr_bits;

  assign bus_ack          = bus_req;
  assign sel              = bus_addr[4:2];
  assign unused_addr_bits = ^{bus_addr[31:5], bus_addr[1:0]};
  assign wr_acc           = bus_req & bus_we;
  assign rd_acc           = bus_req & ~bus_we;
  assign empty            = (count_reg == '0);
  assign full             = (count_reg == CW'(DEPTH));
  assign push             = wr_acc && (sel == A_DATA) && !full;
  assign pop              = rd_acc && (sel == A_DATA) && !empty;

  // Disabled byte lanes are stored as zero rather than left stale
  for (genvar gi = 0; gi < 4; gi++) begin : g_be_mask
    assign push_data[8*gi +: 8] = bus_be[gi] ? bus_wdata[8*gi +: 8] : 8'd0;
  end

  always_comb begin
    count_next   = count_reg;
    irq_en_next  = irq_en_reg;
    irq_lvl_next = irq_lvl_reg;
    ovf_next     = ovf_reg;
    if (push)
      count_next = count_reg + CW'(1);
    else if (pop)
      count_next = count_reg - CW'(1);
    if (wr_acc) begin
      case (sel)
        A_DATA:    if (full && STICKY) ovf_next = 1'b1;
        A_STATUS:  if (STICKY && bus_be[0] && bus_wdata[3]) ovf_next = 1'b0;
        A_IRQ_EN:  if (bus_be[0]) irq_en_next = {STICKY & bus_wdata[1], bus_wdata[0]};
        A_IRQ_LVL: if (bus_be[0]) irq_lvl_next = sat_lvl(bus_wdata[7:0]);
        default: ;
      endcase
    end
    // Interrupt follows the post-transaction state so it rises/falls one cycle after the access
    irq_next = (irq_en_next[0] && (8'(count_next) >= irq_lvl_next)) ||
               (irq_en_next[1] && ovf_next);
  end

  always_comb begin
    reg_rdata_next = '0;
    case (sel)
      A_STATUS:  reg_rdata_next = {16'd0, 8'(count_reg), 4'd0, ovf_reg, 1'b0, full, empty};
      A_IRQ_EN:  reg_rdata_next = {30'd0, irq_en_reg};
      A_IRQ_LVL: reg_rdata_next = {24'd0, irq_lvl_reg};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      irq_en_reg    <= '0;
      irq_lvl_reg   <= sat_lvl(8'(IRQ_LEVEL_DEF));
      ovf_reg       <= 1'b0;
      irq_reg       <= 1'b0;
      resp_reg      <= 1'b0;
      from_ram_reg  <= 1'b0;
      reg_rdata_reg <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg     <= count_next;
      irq_en_reg    <= irq_en_next;
      irq_lvl_reg   <= irq_lvl_next;
      ovf_reg       <= ovf_next;
      irq_reg       <= irq_next;
      resp_reg      <= rd_acc;
      from_ram_reg  <= pop;
      reg_rdata_reg <= reg_rdata_next;
    end
  end

  // Storage kept free of reset so it maps onto block RAM with a registered read port
  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr_reg] <= push_data;
    ram_q_reg <= mem[rd_ptr_reg];
  end

  assign bus_resp  = resp_reg;
  assign bus_rdata = !resp_reg ? 32'd0 : (from_ram_reg ? ram_q_reg : reg_rdata_reg);
  assign irq_o     = irq_reg;
endmodule

// File: tb/tb_mbox_slave.sv
// Randomised scoreboard bench for mbox_slave against a queue-based mailbox model.
module tb_mbox_slave;
  localparam int DEPTH   = 8;
  localparam int LVL_DEF = 1;
`ifdef MBOX_OVERFLOW_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [3:0]  bus_be = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_ack, bus_resp, irq_o;
  logic [31:0] bus_rdata;

  mbox_slave #(.DEPTH(DEPTH), .IRQ_LEVEL_DEF(LVL_DEF)) dut (
    .clk_i(clk), .rst_i(rst_i), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_resp(bus_resp), .bus_rdata(bus_rdata), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;
  logic [31:0] expq[$];

  // Reference mailbox
  logic [31:0] m_fifo[$];
  bit          m_ovf;
  bit [1:0]    m_en;
  int          m_lvl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_ovf = 1'b0;
    m_en  = 2'b00;
    m_lvl = LVL_DEF;
  endtask

  function automatic bit model_irq();
    return (m_en[0] && (m_fifo.size() >= m_lvl)) || (m_en[1] && m_ovf);
  endfunction

  task automatic model_read(input logic [2:0] idx, output logic [31:0] v);
    int n;
    v = '0;
    n = m_fifo.size();
    case (idx)
      3'd0: if (n != 0) v = m_fifo.pop_front();
      3'd1: v = {16'd0, 8'(n), 4'd0, m_ovf, 1'b0, (n == DEPTH), (n == 0)};
      3'd2: v = {30'd0, m_en};
      3'd3: v = 32'(m_lvl);
      default: v = '0;
    endcase
  endtask

  task automatic model_write(input logic [2:0] idx, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] d;
    int unsigned l;
    d = '0;
    case (idx)
      3'd0: begin
        for (int b = 0; b < 4; b++) if (be[b]) d[8*b +: 8] = wd[8*b +: 8];
        if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
        else if (STICKY) m_ovf = 1'b1;
      end
      3'd1: if (STICKY && be[0] && wd[3]) m_ovf = 1'b0;
      3'd2: if (be[0]) m_en = STICKY ? wd[1:0] : {1'b0, wd[0]};
      3'd3: if (be[0]) begin
        l = wd[7:0];
        m_lvl = (l == 0) ? 1 : ((l > DEPTH) ? DEPTH : int'(l));
      end
      default: ;
    endcase
  endtask

  // One bus transaction; leaves the bench at posedge+1 so ops can run back-to-back
  task automatic op(input bit we, input logic [2:0] idx, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] a;
    logic [31:0] exp;
    a = $urandom();
    a[4:2] = idx;
    bus_req = 1'b1; bus_we = we; bus_addr = a; bus_be = be; bus_wdata = wd;
    #1 check("ack", 32'(bus_ack), 32'd1);
    if (we) begin
      model_write(idx, be, wd);
      $display("wr reg%0d be=%h data=0x%08h", idx, be, wd);
    end else begin
      model_read(idx, exp);
      expq.push_back(exp);
      $display("rd reg%0d expect=0x%08h", idx, exp);
    end
    @(posedge clk); #1;
    bus_req = 1'b0; bus_we = 1'b0;
    check("irq", 32'(irq_o), 32'(model_irq()));
  endtask

  task automatic idle(input int n);
    bus_req = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_resp === 1'b1) begin
        check("resp_expected", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) check("rdata", bus_rdata, expq.pop_front());
      end else begin
        check("rdata_idle", bus_rdata, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    check("reset_irq", 32'(irq_o), 32'd0);
    check("reset_resp", 32'(bus_resp), 32'd0);
    check("idle_ack", 32'(bus_ack), 32'd0);
    mon_en = 1'b1;

    op(0, 3'd1, 4'hF, 0);
    op(1, 3'd0, 4'hF, 32'hA5A5_0001);
    op(1, 3'd0, 4'h3, 32'h1234_5678);
    op(0, 3'd0, 4'hF, 0);
    op(0, 3'd0, 4'hF, 0);
    op(0, 3'd1, 4'hF, 0);

    for (int i = 0; i <= DEPTH; i++) op(1, 3'd0, 4'hF, 32'(i));
    op(0, 3'd1, 4'hF, 0);
    for (int i = 0; i <= DEPTH; i++) op(0, 3'd0, 4'hF, 0);
    op(0, 3'd1, 4'hF, 0);
    op(1, 3'd1, 4'h1, 32'h8);
    op(0, 3'd1, 4'hF, 0);

    op(1, 3'd2, 4'hF, 32'h1);
    op(1, 3'd3, 4'hF, 32'h3);
    op(1, 3'd0, 4'hF, 32'h11);
    op(1, 3'd0, 4'hF, 32'h22);
    idle(1);
    op(1, 3'd0, 4'hF, 32'h33);
    idle(1);
    op(0, 3'd0, 4'hF, 0);
    idle(1);
    op(0, 3'd0, 4'hF, 0);
    op(0, 3'd0, 4'hF, 0);
    op(0, 3'd1, 4'hF, 0);

    for (int i = 0; i < 20; i++) begin
      op(1, 3'd0, 4'($urandom_range(0, 15)), $urandom());
      op(0, 3'd1, 4'hF, 0);
      op(0, 3'd0, 4'hF, 0);
    end

    // Reset lands on the same cycle as a DATA read: its response must vanish
    op(1, 3'd0, 4'hF, 32'hDEAD_BEEF);
    op(1, 3'd3, 4'hF, 32'h5);
    idle(2);
    rst_i = 1'b1; bus_req = 1'b1; bus_we = 1'b0; bus_addr = 32'h0; bus_be = 4'hF;
    #1 check("ack_in_reset", 32'(bus_ack), 32'd1);
    @(posedge clk); #1;
    rst_i = 1'b0; bus_req = 1'b0;
    model_reset();
    check("resp_after_rst", 32'(bus_resp), 32'd0);
    check("irq_after_rst", 32'(irq_o), 32'd0);
    op(0, 3'd1, 4'hF, 0);
    op(0, 3'd3, 4'hF, 0);
    op(0, 3'd2, 4'hF, 0);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] idx;
      logic [3:0] be;
      bit we;
      idx = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(0, 7));
      we  = 1'($urandom_range(0, 1));
      be  = (idx == 3'd2 || idx == 3'd3) ? 4'hF : 4'($urandom_range(0, 15));
      w   = $urandom();
      if (idx == 3'd3) w = 32'($urandom_range(0, 12));
      op(we, idx, be, w);
      if ($urandom_range(0, 7) == 0) idle(1);
    end

    idle(4);
    check("drain", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
